// File: rtl/axi_mm2s_pkg.sv
// Shared types and constants for the AXI4 memory-mapped to AXI-Stream reader.
package axi_mm2s_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/mm2s_burst_calc.sv
// Combinational burst sizing: min(remaining beats, MAX_BURST, beats left before the next 4 KiB boundary).
module mm2s_burst_calc
    import axi_mm2s_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic [LEN_WIDTH-1:0] i_remaining,
    input  logic [11:0]          i_addr_lo,
    output logic [8:0]           o_beats
);

    localparam int SIZE = $clog2(DATA_WIDTH / 8);

    logic [12:0] w_bytes_4k;
    logic [12:0] w_beats_4k;
    logic [31:0] w_rem;
    logic [31:0] w_lim;

    always_comb begin
        // Start addresses are beat aligned, so the byte distance divides evenly.
        w_bytes_4k = 13'(BOUNDARY_4K) - {1'b0, i_addr_lo};
        w_beats_4k = w_bytes_4k >> SIZE;
        w_rem      = 32'(i_remaining);
        w_lim      = (32'(w_beats_4k) < 32'(MAX_BURST)) ? 32'(w_beats_4k) : 32'(MAX_BURST);
        o_beats    = 9'((w_rem < w_lim) ? w_rem : w_lim);
    end

endmodule

// File: rtl/axi_mm2s_reader.sv
// AXI4 read master turning {address, beats} commands into one AXI-Stream packet each.
// Define MM2S_ERR_ABORT_EN to truncate the packet after the first burst that returns an error.
module axi_mm2s_reader
    import axi_mm2s_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output state_t                dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic [ADDR_WIDTH-1:0] w_calc_addr;
    logic [LEN_WIDTH-1:0]  w_calc_rem;
    logic [8:0]            w_beats;
    logic                  w_cmd_fire;
    logic                  w_r_fire;
    logic                  w_beat_err;
    logic                  w_last_fire;
    logic                  w_stop;
    logic                  w_pkt_end;
    logic                  w_load_ar;

    assign w_cmd_addr  = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign w_calc_addr = (r_state == IDLE) ? w_cmd_addr : r_addr;
    assign w_calc_rem  = (r_state == IDLE) ? cmd_beats  : r_remaining;

    mm2s_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .i_remaining (w_calc_rem),
        .i_addr_lo   (w_calc_addr[11:0]),
        .o_beats     (w_beats)
    );

    // Every channel transfers on the cycle where valid && ready are both high at the rising edge;
    // valid never waits on ready, and R is passed straight through to the stream only in state R.
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_r_fire    = (r_state == R) && m_axi_rvalid && m_axis_tready;
    assign w_beat_err  = w_r_fire && (m_axi_rresp != AXI_RESP_OKAY);
    assign w_last_fire = w_r_fire && m_axi_rlast;

`ifdef MM2S_ERR_ABORT_EN
    logic r_burst_err;

    assign w_stop = r_burst_err || (m_axi_rresp != AXI_RESP_OKAY);

    always_ff @(posedge ACLK) begin
        if (ARESET || (r_state == AR)) begin
            r_burst_err <= 1'b0;
        end else if (w_beat_err) begin
            r_burst_err <= 1'b1;
        end
    end
`else
    assign w_stop = 1'b0;
`endif

    // r_remaining already excludes the burst in flight, so zero means this is the final burst.
    assign w_pkt_end = (r_remaining == '0) || w_stop;

    always_comb begin
        w_next    = r_state;
        w_load_ar = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    if (cmd_beats == '0) begin
                        w_next = FIN;
                    end else begin
                        w_next    = AR;
                        w_load_ar = 1'b1;
                    end
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    w_next = R;
                end
            end
            R: begin
                if (w_last_fire) begin
                    if (w_pkt_end) begin
                        w_next = FIN;
                    end else begin
                        w_next    = AR;
                        w_load_ar = 1'b1;
                    end
                end
            end
            FIN: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cmd_fire) begin
                r_err <= 1'b0;
            end
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
            if (w_load_ar) begin
                r_araddr    <= w_calc_addr;
                r_arlen     <= 8'(w_beats - 9'd1);
                r_addr      <= w_calc_addr + (ADDR_WIDTH'(w_beats) << SIZE);
                r_remaining <= w_calc_rem - LEN_WIDTH'(w_beats);
            end
        end
    end

    assign cmd_ready     = (r_state == IDLE) && !ARESET;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (r_state == AR);
    assign m_axi_rready  = (r_state == R) && m_axis_tready;
    assign m_axis_tvalid = (r_state == R) && m_axi_rvalid;
    assign m_axis_tdata  = (r_state == R) ? m_axi_rdata : '0;
    assign m_axis_tlast  = (r_state == R) && m_axi_rlast && w_pkt_end;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == FIN);
    assign err           = r_err;
    assign dbg_state     = r_state;

endmodule
